// File: rtl/lm07_sched_pkg.sv
// Shared types and helpers for the LM07 sample scheduler: FSM encoding, widths,
// and sign-magnitude <-> two's complement conversion.
package lm07_sched_pkg;

  localparam int TEMP_W   = 8;
  localparam int SIGNED_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GUARD = 2'd3
  } sched_state_e;

  // -0 (0x80) maps onto 0 naturally since the magnitude is zero.
  function automatic logic signed [SIGNED_W-1:0] sm_to_s(input logic [TEMP_W-1:0] sm);
    logic signed [SIGNED_W-1:0] mag;
    mag = $signed({2'b00, sm[TEMP_W-2:0]});
    return sm[TEMP_W-1] ? -mag : mag;
  endfunction

  function automatic logic [TEMP_W-1:0] s_to_sm(input logic signed [SIGNED_W-1:0] s);
    logic [TEMP_W-2:0] mag;
    mag = s[SIGNED_W-1] ? (TEMP_W-1)'(-s) : (TEMP_W-1)'(s);
    return {s[SIGNED_W-1], mag};
  endfunction

endpackage

// File: rtl/lm07_alarm_hyst.sv
// Over-temperature alarm with hysteresis; evaluated only when a sample is accepted.
module lm07_alarm_hyst
  import lm07_sched_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SIGNED_W-1:0] sample,
  input  logic                       sample_vld,
  input  logic [TEMP_W-1:0]          thr_hi,
  input  logic [TEMP_W-1:0]          thr_lo,
  output logic                       alarm
);

  logic alarm_q, alarm_d;
  logic signed [SIGNED_W-1:0] hi_s, lo_s;

  always_comb begin
    hi_s    = sm_to_s(thr_hi);
    lo_s    = sm_to_s(thr_lo);
    alarm_d = alarm_q;
    // Set is checked first so mis-programmed thresholds resolve to alarm on.
    if (sample_vld) begin
      if (sample >= hi_s)     alarm_d = 1'b1;
      else if (sample < lo_s) alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm_q <= 1'b0;
    else        alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;

endmodule

// File: rtl/lm07_sample_scheduler.sv
// Schedules LM07 reads (periodic + host one-shot), enforces guard gap and timeout,
// holds the last reading and drives the alarm. Optional SCHED_AVG4_EN: 4-sample mean.
module lm07_sample_scheduler
  import lm07_sched_pkg::*;
#(
  parameter int PERIOD_CYCLES  = 1000000,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GUARD_CYCLES   = 16
) (
  input  logic              SYSCLK,
  input  logic              RSTN,
  input  logic              EN,
  input  logic              REQ,
  input  logic [TEMP_W-1:0] THR_HI,
  input  logic [TEMP_W-1:0] THR_LO,
  output logic              RD_START,
  input  logic              RD_DONE,
  input  logic [TEMP_W-1:0] RD_DATA,
  output logic [TEMP_W-1:0] TEMP,
  output logic              TEMP_VALID,
  output logic              ALARM,
  output logic              TIMEOUT_ERR,
  output logic              BUSY
);

  localparam int PER_W   = $clog2(PERIOD_CYCLES);
  localparam int TMR_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  sched_state_e        state_q, state_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                pend_auto_q, pend_auto_d;
  logic                pend_req_q, pend_req_d;
  logic [TEMP_W-1:0]   temp_q, temp_d;
  logic                tvld_q, tvld_d;
  logic                terr_q, terr_d;
  logic                wrap, accept;

  logic signed [SIGNED_W-1:0] rd_s, sample_s;
  logic [TEMP_W-1:0]          temp_new;

  assign rd_s = sm_to_s(RD_DATA);

`ifdef SCHED_AVG4_EN
  // Three previous accepted samples; the new one completes the window of four.
  logic [2:0][SIGNED_W-1:0]   hist_q, hist_d;
  logic                       primed_q, primed_d;
  logic signed [SIGNED_W+1:0] sum;
  logic                       avg_unused;

  always_comb begin
    hist_d   = hist_q;
    primed_d = primed_q;
    if (primed_q)
      sum = (SIGNED_W+2)'(rd_s) + (SIGNED_W+2)'($signed(hist_q[0]))
          + (SIGNED_W+2)'($signed(hist_q[1])) + (SIGNED_W+2)'($signed(hist_q[2]));
    else
      sum = (SIGNED_W+2)'(rd_s) <<< 2;
    if (accept) begin
      primed_d  = 1'b1;
      hist_d[0] = rd_s;
      hist_d[1] = primed_q ? hist_q[0] : rd_s;
      hist_d[2] = primed_q ? hist_q[1] : rd_s;
    end
  end

  // Dropping the two LSBs of the signed sum is an arithmetic floor divide by 4.
  assign sample_s   = sum[SIGNED_W+1:2];
  assign avg_unused = ^sum[1:0];
  assign temp_new   = s_to_sm(sample_s);

  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      hist_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      primed_q <= primed_d;
    end
  end
`else
  assign sample_s = rd_s;
  assign temp_new = RD_DATA;
`endif

  always_comb begin
    state_d     = state_q;
    per_d       = per_q;
    tmr_d       = tmr_q;
    pend_auto_d = pend_auto_q;
    pend_req_d  = pend_req_q;
    temp_d      = temp_q;
    tvld_d      = 1'b0;
    terr_d      = terr_q;
    wrap        = 1'b0;
    accept      = 1'b0;

    if (!EN)                                   per_d = '0;
    else if (per_q == PER_W'(PERIOD_CYCLES-1)) begin per_d = '0; wrap = 1'b1; end
    else                                       per_d = per_q + 1'b1;

    case (state_q)
      ST_IDLE:  if (pend_auto_q || pend_req_q) state_d = ST_START;
      ST_START: begin
        pend_auto_d = 1'b0;
        pend_req_d  = 1'b0;
        tmr_d       = '0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (RD_DONE) begin
          accept  = 1'b1;
          tmr_d   = '0;
          state_d = ST_GUARD;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES-1)) begin
          terr_d  = 1'b1;
          tmr_d   = '0;
          state_d = ST_GUARD;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (tmr_q == TMR_W'(GUARD_CYCLES-1)) begin
          tmr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // New requests land after the START clear so they are held for the next round.
    if (!EN)      pend_auto_d = 1'b0;
    else if (wrap) pend_auto_d = 1'b1;
    if (REQ)      pend_req_d  = 1'b1;

    if (accept) begin
      temp_d = temp_new;
      tvld_d = 1'b1;
      terr_d = 1'b0;
    end
  end

  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      per_q       <= '0;
      tmr_q       <= '0;
      pend_auto_q <= 1'b0;
      pend_req_q  <= 1'b0;
      temp_q      <= '0;
      tvld_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      tmr_q       <= tmr_d;
      pend_auto_q <= pend_auto_d;
      pend_req_q  <= pend_req_d;
      temp_q      <= temp_d;
      tvld_q      <= tvld_d;
      terr_q      <= terr_d;
    end
  end

  lm07_alarm_hyst u_alarm (
    .clk        (SYSCLK),
    .rst_n      (RSTN),
    .sample     (sample_s),
    .sample_vld (accept),
    .thr_hi     (THR_HI),
    .thr_lo     (THR_LO),
    .alarm      (ALARM)
  );

  assign RD_START    = (state_q == ST_START);
  assign BUSY        = (state_q != ST_IDLE);
  assign TEMP        = temp_q;
  assign TEMP_VALID  = tvld_q;
  assign TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_lm07_sample_scheduler.sv
// Scoreboard bench for lm07_sample_scheduler: expected TEMP/ALARM pushed when a read
// is answered, popped and compared on every TEMP_VALID pulse.
module tb_lm07_sample_scheduler;

  localparam int P = 100;
  localparam int T = 20;
  localparam int G = 16;

  logic       SYSCLK = 1'b0;
  logic       RSTN, EN, REQ, RD_DONE;
  logic [7:0] THR_HI, THR_LO, RD_DATA;
  logic       RD_START, TEMP_VALID, ALARM, TIMEOUT_ERR, BUSY;
  logic [7:0] TEMP;

  lm07_sample_scheduler #(.PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T), .GUARD_CYCLES(G)) dut (
    .SYSCLK(SYSCLK), .RSTN(RSTN), .EN(EN), .REQ(REQ), .THR_HI(THR_HI), .THR_LO(THR_LO),
    .RD_START(RD_START), .RD_DONE(RD_DONE), .RD_DATA(RD_DATA), .TEMP(TEMP),
    .TEMP_VALID(TEMP_VALID), .ALARM(ALARM), .TIMEOUT_ERR(TIMEOUT_ERR), .BUSY(BUSY)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct packed { logic [7:0] temp; logic alarm; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_chk = 0, n_pass = 0;
  int rd_start_cnt = 0, vld_cnt = 0;

  int         hist[3];
  bit         primed = 1'b0;
  bit         alarm_m = 1'b0;
  logic [7:0] last_temp = 8'h00;

  function automatic int sm2i(input logic [7:0] v);
    return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
  endfunction

  function automatic logic [7:0] i2sm(input int v);
    return (v < 0) ? {1'b1, 7'(-v)} : {1'b0, 7'(v)};
  endfunction

  task automatic push_exp(input logic [7:0] raw);
    int v, m;
    logic [7:0] t;
    v = sm2i(raw);
`ifdef SCHED_AVG4_EN
    if (!primed) begin hist[0] = v; hist[1] = v; hist[2] = v; primed = 1'b1; end
    m = (v + hist[0] + hist[1] + hist[2]) >>> 2;
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = v;
    t = i2sm(m);
`else
    m = v;
    t = raw;
`endif
    if (m >= sm2i(THR_HI))     alarm_m = 1'b1;
    else if (m < sm2i(THR_LO)) alarm_m = 1'b0;
    sb.push_back('{temp: t, alarm: alarm_m});
    last_temp = t;
  endtask

  always @(negedge SYSCLK) begin
    if (RD_START) rd_start_cnt++;
    if (TEMP_VALID) begin
      vld_cnt++;
      n_chk++;
      if (sb.size() == 0) $display("FAIL sb_unexpected_valid temp=%h", TEMP);
      else begin
        mon_e = sb.pop_front();
        if (TEMP !== mon_e.temp || ALARM !== mon_e.alarm)
          $display("FAIL sb_temp got temp=%h alarm=%b exp temp=%h alarm=%b",
                   TEMP, ALARM, mon_e.temp, mon_e.alarm);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge SYSCLK); #1;
  endtask

  task automatic pulse_req();
    REQ = 1'b1; tick(); REQ = 1'b0;
  endtask

  task automatic do_reset();
    RSTN = 1'b0; EN = 1'b0; REQ = 1'b0; RD_DONE = 1'b0;
    repeat (3) tick();
    RSTN = 1'b1;
    tick();
    primed = 1'b0; alarm_m = 1'b0; last_temp = 8'h00; sb.delete();
  endtask

  task automatic wait_start(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge SYSCLK);
      if (RD_START) begin ok = 1'b1; break; end
    end
    n_chk++;
    if (!ok) $display("FAIL %s no RD_START within 500 cycles got 0 exp 1", name);
    else n_pass++;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge SYSCLK);
      if (!BUSY) begin ok = 1'b1; break; end
    end
    n_chk++;
    if (!ok) $display("FAIL %s BUSY stuck got 1 exp 0", name);
    else n_pass++;
  endtask

  task automatic respond(input int dly, input logic [7:0] d);
    repeat (dly) @(posedge SYSCLK);
    #1 RD_DONE = 1'b1; RD_DATA = d; push_exp(d);
    @(posedge SYSCLK); #1 RD_DONE = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge SYSCLK);
    n_chk++;
    if ({RD_START, TEMP, TEMP_VALID, ALARM, TIMEOUT_ERR, BUSY} !== 13'h0)
      $display("FAIL reset_outputs got %h exp 0", {RD_START, TEMP, TEMP_VALID, ALARM, TIMEOUT_ERR, BUSY});
    else n_pass++;
    RSTN = 1'b1; tick();
    pulse_req(); wait_start("rst_pre"); respond(2, 8'h2A);
    wait_idle("rst_pre_idle");
    pulse_req(); wait_start("rst_wait");
    repeat (2) @(negedge SYSCLK);
    RSTN = 1'b0;
    @(negedge SYSCLK);
    n_chk++;
    if ({RD_START, TEMP, TEMP_VALID, ALARM, TIMEOUT_ERR, BUSY} !== 13'h0)
      $display("FAIL reset_midwait got %h exp 0", {RD_START, TEMP, TEMP_VALID, ALARM, TIMEOUT_ERR, BUSY});
    else n_pass++;
    repeat (2) @(negedge SYSCLK);
    RSTN = 1'b1;
    primed = 1'b0; alarm_m = 1'b0; last_temp = 8'h00; sb.delete();
    begin
      int c0 = rd_start_cnt;
      repeat (40) @(negedge SYSCLK);
      n_chk++;
      if (rd_start_cnt != c0 || BUSY !== 1'b0)
        $display("FAIL reset_no_start got starts=%0d busy=%b exp 0 0", rd_start_cnt - c0, BUSY);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    int c0 = rd_start_cnt, v0 = vld_cnt, busy_bad = 0;
    tick();
    pulse_req(); wait_start("single_start");
    respond(5, 8'h19);
    for (int i = 0; i < G; i++) begin
      @(negedge SYSCLK);
      if (BUSY !== 1'b1) busy_bad++;
    end
    n_chk++;
    if (busy_bad != 0) $display("FAIL single_busy_guard got %0d low cycles exp 0", busy_bad);
    else n_pass++;
    @(negedge SYSCLK);
    n_chk++;
    if (BUSY !== 1'b0) $display("FAIL single_busy_end got %b exp 0", BUSY); else n_pass++;
    n_chk++;
    if (rd_start_cnt - c0 != 1 || vld_cnt - v0 != 1 || TEMP !== 8'h19)
      $display("FAIL single_counts got starts=%0d valids=%0d temp=%h exp 1 1 19",
               rd_start_cnt - c0, vld_cnt - v0, TEMP);
    else n_pass++;
  endtask

  task automatic test_coalesce();
    int c0, n;
    bit ok;
    do_reset();
    c0 = rd_start_cnt;
    EN = 1'b1;
    repeat (P - 1) tick();
    REQ = 1'b1; tick(); REQ = 1'b0;
    wait_start("coal_start");
    EN = 1'b0;
    respond(3, 8'h21);
    repeat (G + 10) @(negedge SYSCLK);
    n_chk++;
    if (rd_start_cnt - c0 != 1) $display("FAIL coal_one_start got %0d exp 1", rd_start_cnt - c0);
    else n_pass++;
    pulse_req(); wait_start("b2b_first");
    tick(); pulse_req();
    @(posedge SYSCLK); #1 RD_DONE = 1'b1; RD_DATA = 8'h0C; push_exp(8'h0C);
    @(posedge SYSCLK); #1 RD_DONE = 1'b0;
    n = 0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge SYSCLK); n++;
      if (RD_START) begin ok = 1'b1; break; end
    end
    n_chk++;
    if (!ok || n != G + 2) $display("FAIL b2b_gap got %0d exp %0d", n, G + 2); else n_pass++;
    respond(2, 8'h0D);
    wait_idle("b2b_idle");
  endtask

  task automatic test_timeout();
    int early = 0;
    pulse_req(); wait_start("tmo_start");
    for (int i = 0; i < T; i++) begin
      @(negedge SYSCLK);
      if (TIMEOUT_ERR !== 1'b0) early++;
    end
    n_chk++;
    if (early != 0) $display("FAIL tmo_early got %0d exp 0", early); else n_pass++;
    @(negedge SYSCLK);
    n_chk++;
    if (TIMEOUT_ERR !== 1'b1 || TEMP !== last_temp)
      $display("FAIL tmo_set got err=%b temp=%h exp 1 %h", TIMEOUT_ERR, TEMP, last_temp);
    else n_pass++;
    wait_idle("tmo_idle");
    tick();
    RD_DONE = 1'b1; RD_DATA = 8'h55; tick(); RD_DONE = 1'b0;
    repeat (3) @(negedge SYSCLK);
    n_chk++;
    if (TEMP !== last_temp || BUSY !== 1'b0 || TIMEOUT_ERR !== 1'b1)
      $display("FAIL stray_done got temp=%h busy=%b err=%b exp %h 0 1", TEMP, BUSY, TIMEOUT_ERR, last_temp);
    else n_pass++;
    tick();
    pulse_req(); wait_start("tmo_recover");
    respond(4, 8'h05);
    @(negedge SYSCLK);
    n_chk++;
    if (TIMEOUT_ERR !== 1'b0) $display("FAIL tmo_clear got %b exp 0", TIMEOUT_ERR); else n_pass++;
    wait_idle("tmo_recover_idle");
  endtask

  task automatic test_alarm();
    logic [7:0] rd [5] = '{8'h1D, 8'h1E, 8'h1B, 8'h18, 8'h85};
    logic       ex [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      tick();
      pulse_req(); wait_start("alarm_start");
      respond(2, rd[i]);
      @(negedge SYSCLK);
`ifndef SCHED_AVG4_EN
      n_chk++;
      if (ALARM !== ex[i]) $display("FAIL alarm_%0d got %b exp %b", i, ALARM, ex[i]);
      else n_pass++;
`else
      if (ex[i] === 1'bx) $display("alarm table corrupt");
`endif
      wait_idle("alarm_idle");
    end
  endtask

`ifdef SCHED_AVG4_EN
  task automatic test_avg();
    logic [7:0] rd [4] = '{8'h14, 8'h18, 8'h84, 8'h00};
    logic [7:0] ex [4] = '{8'h14, 8'h15, 8'h0F, 8'h0A};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse_req(); wait_start("avg_start");
      respond(2, rd[i]);
      @(negedge SYSCLK);
      n_chk++;
      if (TEMP !== ex[i]) $display("FAIL avg_%0d got %h exp %h", i, TEMP, ex[i]);
      else n_pass++;
      wait_idle("avg_idle");
      tick();
    end
  endtask
`endif

  initial begin
    RSTN = 1'b0; EN = 1'b0; REQ = 1'b0; RD_DONE = 1'b0; RD_DATA = 8'h00;
    THR_HI = 8'h1E; THR_LO = 8'h19;
    test_reset();
    test_single();
    test_coalesce();
    test_timeout();
    test_alarm();
`ifdef SCHED_AVG4_EN
    test_avg();
`endif
    repeat (3) @(negedge SYSCLK);
    n_chk++;
    if (sb.size() != 0) $display("FAIL sb_leftover got %0d exp 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
